// File: rtl/sar_search_controller.sv
// sar_search_controller: successive-approximation search over a magnitude comparator.
// It drives the trial value onto the comparator's B operand and reads back the
// gt/lt/eq flags. It settles MSB-first on the value present at the comparator's A operand.
// Optional feature: define SAR_EARLY_EXIT_EN to end a search as soon as the comparator reports equality.
module sar_search_controller #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             A_gt_B,
    input  logic             A_lt_B,
    input  logic             A_eq_B,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_err
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    IDX_MSB   = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TRIAL_MSB = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  trial_q, trial_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              flag_err_q, flag_err_d;

    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  kept;
    logic [1:0]        flag_cnt;
    logic              flags_one_hot;

    // Decode the current bit under test and judge the comparator response.
    always_comb begin
        mask          = WIDTH'(1) << idx_q;
        kept          = A_lt_B ? (trial_q & ~mask) : trial_q;
        flag_cnt      = 2'(A_gt_B) + 2'(A_lt_B) + 2'(A_eq_B);
        flags_one_hot = (flag_cnt == 2'd1);
    end

    // Next-state and next-register values for the search sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        trial_d    = trial_q;
        idx_d      = idx_q;
        result_d   = result_q;
        flag_err_d = flag_err_q;

        case (state_q)
            IDLE: begin
                trial_d = '0;
                if (start) begin
                    trial_d    = TRIAL_MSB;
                    idx_d      = IDX_MSB;
                    flag_err_d = 1'b0;
                    state_d    = TRY;
                end
            end
            TRY: begin
                if (!flags_one_hot) begin
                    // Broken comparator response: report the trial we were on and stop.
                    flag_err_d = 1'b1;
                    result_d   = trial_q;
                    state_d    = DONE;
`ifdef SAR_EARLY_EXIT_EN
                end else if (A_eq_B) begin
                    result_d = trial_q;
                    state_d  = DONE;
`endif
                end else if (idx_q == '0) begin
                    result_d = kept;
                    state_d  = DONE;
                end else begin
                    trial_d = kept | (mask >> 1);
                    idx_d   = idx_q - 1'b1;
                end
            end
            DONE: begin
                trial_d = '0;
                state_d = IDLE;
            end
            default: begin
                trial_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any search in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q    <= IDLE;
            trial_q    <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            flag_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trial_q    <= trial_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            flag_err_q <= flag_err_d;
        end
    end

    assign trial    = trial_q;
    assign busy     = (state_q == TRY);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign flag_err = flag_err_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Testbench for sar_search_controller (WIDTH=4). A behavioural comparator drives the flags.
// Expected results are pushed to a scoreboard queue when a search is launched. They are
// popped and compared when done pulses.
module tb_sar_search_controller;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         A_gt_B, A_lt_B, A_eq_B;
    logic [W-1:0] trial;
    logic         busy, done;
    logic [W-1:0] result;
    logic         flag_err;

    logic [W-1:0] target;
    logic         bad_flags;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb[$];

    sar_search_controller #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A_gt_B   (A_gt_B),
        .A_lt_B   (A_lt_B),
        .A_eq_B   (A_eq_B),
        .trial    (trial),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flag_err (flag_err)
    );

    always #5 clk = ~clk;

    // Combinational comparator, with an override that asserts gt and lt together.
    assign A_gt_B = bad_flags ? 1'b1 : (target > trial);
    assign A_lt_B = bad_flags ? 1'b1 : (target < trial);
    assign A_eq_B = bad_flags ? 1'b0 : (target == trial);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference trial sequence for a target: binary search, MSB first.
    task automatic expected_trials(input logic [W-1:0] tgt, output logic [W-1:0] q[$]);
        logic [W-1:0] t;
        q = {};
        t = '0;
        t[W-1] = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            q.push_back(t);
`ifdef SAR_EARLY_EXIT_EN
            if (tgt == t) break;
`endif
            if (tgt < t) t[i] = 1'b0;
            if (i > 0) t[i-1] = 1'b1;
        end
    endtask

    // One complete search; optionally pulse start during TRY, which must be ignored.
    task automatic run_search(input logic [W-1:0] tgt, input bit pulse_mid);
        logic [W-1:0] exp_q[$];
        int n;
        expected_trials(tgt, exp_q);
        target = tgt;
        sb.push_back(tgt);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            if (n < exp_q.size()) check("trial", trial, exp_q[n]);
            else                  check("trial_extra", trial, 0);
            if (n == 0) check("flag_err_clear", flag_err, 0);
            if (pulse_mid && n == 1) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        check("compare_cycles", n, exp_q.size());
        check("done_pulse", done, 1);
        if (sb.size() > 0) check("result", result, sb.pop_front());
        else               check("sb_empty", 1, 0);
        check("flag_err", flag_err, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("idle_trial", trial, 0);
        tick();
        check("start_not_queued", busy, 0);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        int cyc;
        logic prev_busy;

        reset = 1'b1;
        start = 1'b0;
        target = '0;
        bad_flags = 1'b0;
        tick();
        tick();
        check("rst_trial", trial, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flag_err", flag_err, 0);
        reset = 1'b0;
        tick();

        // Directed targets: mixed flags, all-lt, all-gt, equality on the MSB.
        run_search(4'b1011, 1'b0);
        run_search(4'b0000, 1'b0);
        run_search(4'b1111, 1'b0);
        run_search(4'b1000, 1'b0);

        // Invalid flags on the 2nd TRY cycle.
        target = 4'b1011;
        sb.push_back(4'b1100);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bad_trial1", trial, 4'b1000);
        tick();
        check("bad_trial2", trial, 4'b1100);
        bad_flags = 1'b1;
        tick();
        bad_flags = 1'b0;
        check("bad_done", done, 1);
        check("bad_flag_err", flag_err, 1);
        check("bad_result", result, sb.pop_front());
        tick();
        check("bad_flag_sticky", flag_err, 1);
        check("bad_done_once", done, 0);
        run_search(4'b0110, 1'b0);

        // Reset in the 3rd TRY cycle aborts without a done pulse.
        target = 4'b1011;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_trial", trial, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);
        run_search(4'b1011, 1'b0);

        // Start pulsed during TRY is ignored.
        run_search(4'b0101, 1'b1);

        // Start held high: back-to-back searches every W+2 cycles.
        target = 4'b0000;
        start = 1'b1;
        prev_busy = 1'b0;
        done_cnt = 0;
        last_done = -1;
        for (cyc = 0; cyc < 60; cyc++) begin
            tick();
            if (cyc == 40) start = 1'b0;
            if (busy && !prev_busy) sb.push_back(target);
            if (done) begin
                if (last_done >= 0) check("hold_spacing", cyc - last_done, W + 2);
                last_done = cyc;
                done_cnt++;
                if (sb.size() > 0) check("hold_result", result, sb.pop_front());
                else               check("hold_sb_empty", 1, 0);
            end
            prev_busy = busy;
        end
        check("hold_searches", done_cnt >= 6, 1);
        check("hold_drained", sb.size(), 0);
        sb.delete();

        // Exhaustive sweep.
        for (int t = 0; t < (1 << W); t++) run_search(W'(t), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
